seq_onehot_decoder: RTL and testbench
=====================================

Name: seq_onehot_decoder

Overview:
- Registered, parametrised N-to-2^N one-hot decoder. Successor to the fixed 4-to-16 combinational decoder.
- Two modes:
  - Direct mode: loads an address through a valid/ready handshake.
  - Scan mode: walks the one-hot output through every line with a programmable dwell and a wrap pulse.
- Used for register-file/row selection and for display or bank scanning in the datapath.

Parameters:
- N, 4, select width; output width is 2**N.
- DWELL, 4, cycles each line stays active in scan mode (legal range 1..255).
- DW_W, 8, width of the internal dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; 0 forces outputs inactive and freezes state.
- mode  input  1  0 = direct, 1 = scan.
- in_valid  input  1  in_addr is valid.
- in_ready  output  1  block accepts in_addr this cycle (combinational).
- in_addr  input  N  address to decode in direct mode.
- y  output  2**N  registered one-hot select; all-zero when inactive.
- cur_addr  output  N  registered address currently decoded.
- y_valid  output  1  registered; y holds a valid one-hot.
- wrap  output  1  one-cycle pulse when scan steps from 2**N-1 to 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - y=0, cur_addr=0, y_valid=0, wrap=0, dwell counter=0.
  - Takes effect immediately, including mid-scan or mid-handshake.
- Invariant, checked every cycle: y == (y_valid ? 1<<cur_addr : 0). y is never multi-hot.
- in_ready = en & ~mode. It is purely combinational and does not depend on in_valid.
- en=0:
  - Next edge: y_valid<=0, y<=0, wrap<=0.
  - cur_addr and the dwell counter hold.
  - No transfer is accepted.
- Direct mode (mode=0, en=1):
  - A transfer occurs when in_valid & in_ready.
  - Next edge after a transfer: cur_addr<=in_addr, y<=1<<in_addr, y_valid<=1. Latency is 1 cycle.
  - With no transfer, all state holds; after re-enable, y_valid stays 0 until the next transfer.
  - wrap=0 in this mode.
- Scan mode (mode=1, en=1):
  - Next edge: y_valid<=1, y reflects cur_addr.
  - Dwell counter increments each cycle. When it equals DWELL-1, it clears and cur_addr<=cur_addr+1 (mod 2**N).
  - y updates on the same edge as cur_addr.
  - wrap<=1 for exactly one cycle on the edge where cur_addr goes 2**N-1 -> 0; otherwise wrap<=0.
  - DWELL=1: cur_addr steps every cycle.
- Mode switches:
  - 0->1: scan starts from the current cur_addr with the dwell counter cleared. The first step occurs DWELL cycles after entry.
  - 1->0: cur_addr holds, dwell counter clears, y stays active; the next transfer overrides cur_addr.
  - A transfer is accepted in the same cycle mode falls to 0.
- en and mode changing on the same edge: en has priority.
- in_addr out of range is impossible because it is N bits. in_valid while in_ready=0 is ignored, not queued.

Decomposition:
- Shared package/header:
  - Mode encodings MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - Macro/function for the one-hot width (1<<N).
- One natural sub-module: dec_nx2n, a combinational parametrised N-to-2^N decoder (one-hot of input, plus enable).
  - Instantiated once on the next-state cur_addr.
  - Its output is registered into y.
- The top level holds the dwell counter, cur_addr register, handshake and mode control.

Test Plan (N=4, DWELL=3 unless noted):
- Reset/direct: assert rst_n=0 mid-cycle -> y=0, y_valid=0 immediately. Release, then mode=0, en=1, in_valid=1, in_addr=4'hA -> next cycle y=16'h0400, cur_addr=A, y_valid=1.
- Scan stepping and wrap: direct-load 4'hE, then mode=1 -> y=0x4000 for 3 cycles, 0x8000 for 3 cycles, then 0x0001 with wrap=1 for exactly one cycle.
- Enable gating: during scan at cur_addr=5, en=0 for 4 cycles -> y=0, y_valid=0, in_ready=0, cur_addr stays 5. en=1 -> resumes at 5 with the dwell counter preserved.
- Handshake: mode=1 with in_valid=1, in_addr=3 -> in_ready=0, no load. Switch mode=0 in the same cycle in_valid=1, in_addr=3 -> accepted, y=16'h0008 next cycle.
- DWELL=1, N=3 build: mode=1 from reset -> y cycles 01,02,04,...,80,01 each cycle, wrap once per 8 cycles.
- Async reset mid-scan at cur_addr=9 -> immediately all outputs 0. After release with mode=1, scan restarts at 0.

Source files
------------

// File: rtl/seq_onehot_decoder_pkg.sv
// seq_onehot_decoder_pkg: shared mode encodings and the one-hot width helper
// Contents:
//   mode_e    - MODE_DIRECT (address load) / MODE_SCAN (walk every line)
//   onehot_w  - output width of an n-bit one-hot decoder (1 << n)
package seq_onehot_decoder_pkg;
    typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
    function automatic int onehot_w(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/seq_onehot_decoder_dec_nx2n.sv
// dec_nx2n: combinational N-to-2^N one-hot decoder with enable
// Ports:
//   a  - address to decode
//   en - 0 forces an all-zero output
//   y  - one-hot of a when en, else zero
module dec_nx2n
    import seq_onehot_decoder_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           a,
    input  logic                   en,
    output logic [onehot_w(N)-1:0] y
);
    localparam int W = onehot_w(N);
    assign y = en ? W'(1) << a : '0;
endmodule

// File: rtl/seq_onehot_decoder.sv
// seq_onehot_decoder: registered N-to-2^N one-hot decoder with direct load and dwell-timed scan
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   en         - 0 blanks the outputs and freezes cur_addr / dwell counter
//   mode       - MODE_DIRECT loads in_addr via valid/ready, MODE_SCAN walks all lines
//   in_valid   - in_addr is valid
//   in_ready   - combinational en & direct mode
//   in_addr    - address to decode in direct mode
//   y          - registered one-hot select, zero when y_valid is low
//   cur_addr   - registered address currently decoded
//   y_valid    - y holds a valid one-hot
//   wrap       - one-cycle pulse when the scan steps from the last line to 0
module seq_onehot_decoder
    import seq_onehot_decoder_pkg::*;
#(
    parameter int N     = 4,
    parameter int DWELL = 4,
    parameter int DW_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_addr,
    output logic [onehot_w(N)-1:0] y,
    output logic [N-1:0]           cur_addr,
    output logic                   y_valid,
    output logic                   wrap
);
    localparam int W = onehot_w(N);
    logic [N-1:0]    cur_n;
    logic [DW_W-1:0] cnt, cnt_n;
    logic            yv_n, wrap_n, last;
    logic [W-1:0]    y_n;
    assign in_ready = en & (mode == MODE_DIRECT);
    assign last     = cnt == DW_W'(DWELL - 1);
    // Direct mode keeps the dwell counter at zero so a later scan entry
    // always dwells the full DWELL cycles on its first line.
    always_comb begin
        cur_n  = cur_addr;
        cnt_n  = cnt;
        yv_n   = 1'b0;
        wrap_n = 1'b0;
        if (en && mode == MODE_SCAN) begin
            yv_n   = 1'b1;
            cnt_n  = last ? '0 : cnt + 1'b1;
            cur_n  = last ? cur_addr + 1'b1 : cur_addr;
            wrap_n = last & (&cur_addr);
        end else if (en) begin
            cnt_n = '0;
            yv_n  = y_valid | in_valid;
            cur_n = in_valid ? in_addr : cur_addr;
        end
    end
    // Decoding the next-state address lets y land on the same edge as cur_addr.
    dec_nx2n #(.N(N)) u_dec (
        .a  (cur_n),
        .en (yv_n),
        .y  (y_n)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            cur_addr <= '0;
            y_valid  <= 1'b0;
            wrap     <= 1'b0;
            cnt      <= '0;
        end else begin
            y        <= y_n;
            cur_addr <= cur_n;
            y_valid  <= yv_n;
            wrap     <= wrap_n;
            cnt      <= cnt_n;
        end
    end
endmodule

// File: tb/tb_seq_onehot_decoder.sv
// tb_seq_onehot_decoder: vector table, reset/DWELL=1 sequences and random run against a line-timing model
module tb_seq_onehot_decoder;
    localparam int DWELL = 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, en = 1'b0, mode = 1'b0, in_valid = 1'b0, in_ready;
    logic [3:0]  in_addr = '0, cur_addr;
    logic [15:0] y;
    logic        y_valid, wrap;
    logic        rst2_n = 1'b0, en2 = 1'b1, mode2 = 1'b1, iv2 = 1'b0, rdy2, yv2, wrap2;
    logic [2:0]  ia2 = '0, cur2;
    logic [7:0]  y2;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    seq_onehot_decoder #(.N(4), .DWELL(DWELL), .DW_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_addr(in_addr), .y(y), .cur_addr(cur_addr),
        .y_valid(y_valid), .wrap(wrap)
    );
    seq_onehot_decoder #(.N(3), .DWELL(1), .DW_W(8)) dut1 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .in_valid(iv2),
        .in_ready(rdy2), .in_addr(ia2), .y(y2), .cur_addr(cur2),
        .y_valid(yv2), .wrap(wrap2)
    );

    typedef struct {
        logic        en, mode, iv;
        logic [3:0]  a;
        logic        rdy;
        logic [15:0] y;
        logic [3:0]  cur;
        logic        yv, wr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic e, logic m, logic v, logic [3:0] a, logic r,
                                logic [15:0] ey, logic [3:0] ec, logic eyv, logic ew);
        vec_t t;
        t.en = e; t.mode = m; t.iv = v; t.a = a; t.rdy = r;
        t.y = ey; t.cur = ec; t.yv = eyv; t.wr = ew;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic e, input logic m, input logic v, input logic [3:0] a);
        @(negedge clk);
        en = e; mode = m; in_valid = v; in_addr = a;
        #1;
    endtask

    // Reference: a line is shown for DWELL enabled scan cycles, then the next one.
    int  m_addr, m_el;
    bit  m_val, m_wrap;
    task automatic model_reset();
        m_addr = 0; m_el = 0; m_val = 0; m_wrap = 0;
    endtask
    task automatic model_step(input bit e, input bit m, input bit v, input int a);
        m_wrap = 0;
        if (!e) m_val = 0;
        else if (!m) begin
            m_el = 0;
            if (v) begin m_addr = a; m_val = 1; end
        end else begin
            m_val = 1;
            m_el++;
            if (m_el == DWELL) begin
                m_el   = 0;
                m_wrap = (m_addr == 15);
                m_addr = (m_addr + 1) % 16;
            end
        end
    endtask

    initial begin
        #2;
        chk("reset_outputs", {y, cur_addr, y_valid, wrap}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.push_back(mk(1,0,1,4'hA, 1, 16'h0400, 4'hA, 1, 0));
        tbl.push_back(mk(1,0,0,4'h3, 1, 16'h0400, 4'hA, 1, 0));
        tbl.push_back(mk(1,0,1,4'hE, 1, 16'h4000, 4'hE, 1, 0));
        tbl.push_back(mk(1,1,1,4'h3, 0, 16'h4000, 4'hE, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h4000, 4'hE, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h8000, 4'hF, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h8000, 4'hF, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h8000, 4'hF, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0001, 4'h0, 1, 1));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0001, 4'h0, 1, 0));
        tbl.push_back(mk(1,1,1,4'h3, 0, 16'h0001, 4'h0, 1, 0));
        tbl.push_back(mk(1,0,1,4'h3, 1, 16'h0008, 4'h3, 1, 0));
        tbl.push_back(mk(0,0,1,4'h5, 0, 16'h0000, 4'h3, 0, 0));
        tbl.push_back(mk(1,0,0,4'h5, 1, 16'h0000, 4'h3, 0, 0));
        tbl.push_back(mk(1,0,1,4'h5, 1, 16'h0020, 4'h5, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0020, 4'h5, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,0,4'h0, 0, 16'h0000, 4'h5, 0, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0020, 4'h5, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0040, 4'h6, 1, 0));
        tbl.push_back(mk(1,0,0,4'h0, 1, 16'h0040, 4'h6, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0040, 4'h6, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0040, 4'h6, 1, 0));
        tbl.push_back(mk(1,1,0,4'h0, 0, 16'h0080, 4'h7, 1, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].iv, tbl[i].a);
            chk($sformatf("vec%0d_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].rdy});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out", i), {y, cur_addr, y_valid, wrap},
                {10'b0, tbl[i].y, tbl[i].cur, tbl[i].yv, tbl[i].wr});
        end

        // async reset mid-scan at line 9, then scan restarts from 0
        drive(1, 0, 1, 4'h9);
        drive(1, 1, 0, 4'h0);
        @(posedge clk); #1;
        chk("pre_reset_scan", {y, cur_addr, y_valid}, {11'b0, 16'h0200, 4'h9, 1'b1});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {y, cur_addr, y_valid, wrap}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("restart_edge%0d", k), {y, cur_addr, y_valid, wrap},
                {10'b0, 16'(1) << (k / DWELL), 4'(k / DWELL), 1'b1, 1'b0});
        end

        // DWELL=1, N=3: one line per cycle, one wrap per 8 cycles
        begin
            int wraps = 0;
            @(negedge clk);
            rst2_n = 1'b1;
            for (int k = 1; k <= 17; k++) begin
                @(posedge clk); #1;
                wraps += int'(wrap2);
                chk($sformatf("d1_edge%0d", k), {y2, cur2, yv2, wrap2},
                    {19'b0, 8'(1) << (k % 8), 3'(k % 8), 1'b1, 1'(k % 8 == 0)});
            end
            chk("d1_wrap_count", wraps, 2);
        end

        // randomized run against the model
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        begin
            bit e, m = 0, v;
            int a;
            for (int c = 0; c < 1500; c++) begin
                e = ($urandom % 8) != 0;
                if ($urandom % 20 == 0) m = ~m;
                v = $urandom % 2;
                a = $urandom % 16;
                drive(e, m, v, 4'(a));
                chk($sformatf("rnd%0d_ready", c), {31'b0, in_ready}, {31'b0, e & ~m});
                model_step(e, m, v, a);
                @(posedge clk); #1;
                chk($sformatf("rnd%0d_out", c), {y, cur_addr, y_valid, wrap},
                    {10'b0, m_val ? 16'(1) << m_addr : 16'h0, 4'(m_addr), m_val, m_wrap});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
